// File: rtl/padder_drain.sv
// Collects results from the 4-stage pipelined adder into an output FIFO.
// Tags track real operations, and credits throttle issue so the FIFO never overflows.
module padder_drain #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned SEQW    = 8
) (
   input  logic            Clock,
   input  logic            Reset_n,
   input  logic            InValid,
   output logic            InReady,
   input  logic [31:0]     PS,
   input  logic            PCO,
   output logic            OutValid,
   input  logic            OutReady,
   output logic [31:0]     OutSum,
   output logic            OutCarry,
   output logic [SEQW-1:0] OutSeq,
   output logic            Overflow
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
   localparam logic [PW-1:0] L_LAST  = PW'(DEPTH - 1);

   logic [SEQW-1:0]    r_seq;
   logic [LATENCY-1:0] r_tag_v;
   logic [SEQW-1:0]    r_tag_seq [LATENCY];
   logic [CW-1:0]      r_inflight;
   logic [CW-1:0]      r_count;
   logic [PW-1:0]      r_wptr;
   logic [PW-1:0]      r_rptr;
   logic [31:0]        r_mem_sum   [DEPTH];
   logic [DEPTH-1:0]   r_mem_carry;
   logic [SEQW-1:0]    r_mem_seq   [DEPTH];
   logic               r_overflow;

   logic               w_issue;
   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_write;
   logic [CW:0]        w_used;

   // Credits are derived from registered state only, so a freed slot shows up next cycle.
   assign w_used   = {1'b0, r_count} + {1'b0, r_inflight};
   assign InReady  = (w_used < {1'b0, L_DEPTH});
   assign OutValid = (r_count != '0);
   assign w_issue  = InValid & InReady;
   assign w_push   = r_tag_v[LATENCY-1];
   assign w_pop    = OutValid & OutReady;
   assign w_full   = (r_count == L_DEPTH);
   assign w_write  = w_push & (~w_full | w_pop);

   assign OutSum   = r_mem_sum[r_rptr];
   assign OutCarry = r_mem_carry[r_rptr];
   assign OutSeq   = r_mem_seq[r_rptr];
   assign Overflow = r_overflow;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_seq      <= '0;
         r_tag_v    <= '0;
         r_inflight <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) begin
            r_tag_seq[i] <= '0;
         end
      end else begin
         if (w_issue) begin
            r_seq <= r_seq + SEQW'(1);
         end
         r_tag_v[0]   <= w_issue;
         r_tag_seq[0] <= r_seq;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            r_tag_v[i]   <= r_tag_v[i-1];
            r_tag_seq[i] <= r_tag_seq[i-1];
         end
         case ({w_issue, w_push})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_mem_carry <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem_sum[i] <= '0;
            r_mem_seq[i] <= '0;
         end
      end else begin
         if (w_write) begin
            r_mem_sum[r_wptr]   <= PS;
            r_mem_carry[r_wptr] <= PCO;
            r_mem_seq[r_wptr]   <= r_tag_seq[LATENCY-1];
            r_wptr              <= (r_wptr == L_LAST) ? '0 : r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == L_LAST) ? '0 : r_rptr + PW'(1);
         end
         // A push into a full FIFO is only dropped when no pop frees the slot.
         if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
